// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - IF/ID/EX branch tracking, EX resolution, redirect/flush and perf counters
// Predictions ride down the pipe with each instruction and are compared against the resolved next PC in EX.
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IM_stall,
  input  logic                 DM_stall,
  input  logic                 hazardStall,
  input  logic [15:0]          fetchPc,
  input  logic                 fetchHit,
  input  logic [15:0]          fetchTarget,
  input  logic [1:0]           idBranchType,
  input  logic                 exCondTrue,
  input  logic [15:0]          exComputedTarget,
  output logic [1:0]           exBranchType,
  output logic                 exTaken,
  output logic [15:0]          exPc,
  output logic [15:0]          exTarget,
  output logic                 redirect,
  output logic [15:0]          redirectPc,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] branchCnt,
  output logic [CNT_WIDTH-1:0] mispredCnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 r_ifid_valid;
  logic [15:0]          r_ifid_pc;
  logic                 r_ifid_pred_taken;
  logic [15:0]          r_ifid_pred_target;
  logic                 r_idex_valid;
  logic [15:0]          r_idex_pc;
  logic                 r_idex_pred_taken;
  logic [15:0]          r_idex_pred_target;
  logic [1:0]           r_idex_type;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  logic        w_gstall;
  logic        w_act_taken;
  logic [15:0] w_pc_plus4;
  logic [15:0] w_act_next;
  logic [15:0] w_pred_next;
  logic        w_mispred;
  logic        w_cnt_en;
  logic        w_kill;

  assign w_gstall = IM_stall | DM_stall;

  always_comb begin
    w_act_taken = 1'b0;
    case (r_idex_type)
      2'b01, 2'b11: w_act_taken = 1'b1;
      2'b10:        w_act_taken = exCondTrue;
      default:      w_act_taken = 1'b0;
    endcase
  end

  assign w_pc_plus4  = r_idex_pc + 16'd4;
  assign w_act_next  = w_act_taken ? exComputedTarget : w_pc_plus4;
  assign w_pred_next = r_idex_pred_taken ? r_idex_pred_target : w_pc_plus4;
  // Comparing full next-PCs catches wrong targets as well as wrong directions.
  assign w_mispred   = r_idex_valid & (w_act_next != w_pred_next);
  assign w_kill      = w_mispred & ~w_gstall;
  assign w_cnt_en    = ~w_gstall & r_idex_valid & (r_idex_type != 2'b00);

  assign redirect     = w_kill;
  assign flush        = w_kill;
  assign redirectPc   = w_act_next;
  // JALR targets are register-dependent, so they never train the predictor.
  assign exBranchType = (r_idex_valid && (r_idex_type == 2'b01 || r_idex_type == 2'b10)) ? r_idex_type : 2'b00;
  assign exTaken      = w_act_taken;
  assign exPc         = r_idex_pc;
  assign exTarget     = exComputedTarget;
  assign branchCnt    = r_branch_cnt;
  assign mispredCnt   = r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ifid_valid       <= 1'b0;
      r_ifid_pc          <= 16'd0;
      r_ifid_pred_taken  <= 1'b0;
      r_ifid_pred_target <= 16'd0;
      r_idex_valid       <= 1'b0;
      r_idex_pc          <= 16'd0;
      r_idex_pred_taken  <= 1'b0;
      r_idex_pred_target <= 16'd0;
      r_idex_type        <= 2'b00;
      r_branch_cnt       <= '0;
      r_mispred_cnt      <= '0;
    end else if (!w_gstall) begin
      if (w_cnt_en) begin
        if (r_branch_cnt != CNT_MAX) r_branch_cnt <= r_branch_cnt + CNT_ONE;
        if (w_mispred && r_mispred_cnt != CNT_MAX) r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
      end
      if (w_kill) begin
        r_ifid_valid <= 1'b0;
        r_idex_valid <= 1'b0;
      end else if (hazardStall) begin
        r_idex_valid <= 1'b0;
      end else begin
        r_idex_valid       <= r_ifid_valid;
        r_idex_pc          <= r_ifid_pc;
        r_idex_pred_taken  <= r_ifid_pred_taken;
        r_idex_pred_target <= r_ifid_pred_target;
        r_idex_type        <= idBranchType;
        r_ifid_valid       <= 1'b1;
        r_ifid_pc          <= fetchPc;
        r_ifid_pred_taken  <= fetchHit;
        r_ifid_pred_target <= fetchTarget;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks of branch_resolve_unit against a pipeline model
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, IM_stall, DM_stall, hazardStall, fetchHit, exCondTrue;
  logic [15:0] fetchPc, fetchTarget, exComputedTarget;
  logic [1:0]  idBranchType;

  logic [1:0]  exBranchType, exBranchType4;
  logic        exTaken, exTaken4, redirect, redirect4, flush, flush4;
  logic [15:0] exPc, exPc4, exTarget, exTarget4, redirectPc, redirectPc4;
  logic [31:0] branchCnt, mispredCnt;
  logic [3:0]  branchCnt4, mispredCnt4;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall), .hazardStall(hazardStall),
    .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget), .idBranchType(idBranchType),
    .exCondTrue(exCondTrue), .exComputedTarget(exComputedTarget), .exBranchType(exBranchType),
    .exTaken(exTaken), .exPc(exPc), .exTarget(exTarget), .redirect(redirect), .redirectPc(redirectPc),
    .flush(flush), .branchCnt(branchCnt), .mispredCnt(mispredCnt)
  );

  branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .IM_stall(IM_stall), .DM_stall(DM_stall), .hazardStall(hazardStall),
    .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget), .idBranchType(idBranchType),
    .exCondTrue(exCondTrue), .exComputedTarget(exComputedTarget), .exBranchType(exBranchType4),
    .exTaken(exTaken4), .exPc(exPc4), .exTarget(exTarget4), .redirect(redirect4), .redirectPc(redirectPc4),
    .flush(flush4), .branchCnt(branchCnt4), .mispredCnt(mispredCnt4)
  );

  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic        pt;
    logic [15:0] ptg;
    logic [1:0]  ty;
  } ent_t;

  ent_t        m_ifid, m_idex;
  int unsigned m_br, m_mp;
  bit          m_init = 0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned sat4(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  // Drive one cycle of inputs and check every output against the model's view of EX.
  task automatic drv(input logic r, input logic ims, input logic dms, input logic hs,
                     input logic [15:0] fpc, input logic fhit, input logic [15:0] ftgt,
                     input logic [1:0] bt, input logic cond, input logic [15:0] ctgt);
    logic        tk, mis, red;
    logic [15:0] an, pn;
    logic [1:0]  ebt;
    @(negedge clk);
    rst = r; IM_stall = ims; DM_stall = dms; hazardStall = hs;
    fetchPc = fpc; fetchHit = fhit; fetchTarget = ftgt; idBranchType = bt;
    exCondTrue = cond; exComputedTarget = ctgt;
    #1;
    if (!m_init) return;
    tk  = (m_idex.ty == 2'd1 || m_idex.ty == 2'd3) ? 1'b1 : (m_idex.ty == 2'd2) ? cond : 1'b0;
    an  = tk ? ctgt : 16'((32'(m_idex.pc) + 4) % 65536);
    pn  = m_idex.pt ? m_idex.ptg : 16'((32'(m_idex.pc) + 4) % 65536);
    mis = m_idex.v && (an != pn);
    red = mis && !(ims || dms);
    ebt = (m_idex.v && (m_idex.ty == 2'd1 || m_idex.ty == 2'd2)) ? m_idex.ty : 2'd0;
    chk("redirect", redirect, red);
    chk("flush", flush, red);
    chk("exBranchType", exBranchType, ebt);
    chk("exTarget", exTarget, ctgt);
    chk("branchCnt", branchCnt, m_br);
    chk("mispredCnt", mispredCnt, m_mp);
    chk("redirect_w4", redirect4, red);
    chk("branchCnt_w4", branchCnt4, sat4(m_br));
    chk("mispredCnt_w4", mispredCnt4, sat4(m_mp));
    if (m_idex.v) begin
      chk("redirectPc", redirectPc, an);
      chk("exTaken", exTaken, tk);
      chk("exPc", exPc, m_idex.pc);
      chk("exBranchType_w4", exBranchType4, ebt);
    end
  endtask

  // Advance the model across the clock edge using the inputs held by drv.
  task automatic tick();
    logic tk, mis;
    logic [15:0] an, pn;
    @(posedge clk);
    tk  = (m_idex.ty == 2'd1 || m_idex.ty == 2'd3) ? 1'b1 : (m_idex.ty == 2'd2) ? exCondTrue : 1'b0;
    an  = tk ? exComputedTarget : 16'((32'(m_idex.pc) + 4) % 65536);
    pn  = m_idex.pt ? m_idex.ptg : 16'((32'(m_idex.pc) + 4) % 65536);
    mis = m_idex.v && (an != pn);
    if (!rst) begin
      m_ifid = '{1'b0, 16'd0, 1'b0, 16'd0, 2'd0};
      m_idex = '{1'b0, 16'd0, 1'b0, 16'd0, 2'd0};
      m_br = 0; m_mp = 0; m_init = 1;
    end else if (m_init && !(IM_stall || DM_stall)) begin
      if (m_idex.v && m_idex.ty != 2'd0) begin
        m_br++;
        if (mis) m_mp++;
      end
      if (mis) begin
        m_ifid.v = 1'b0;
        m_idex.v = 1'b0;
      end else if (hazardStall) begin
        m_idex.v = 1'b0;
      end else begin
        m_idex = '{m_ifid.v, m_ifid.pc, m_ifid.pt, m_ifid.ptg, idBranchType};
        m_ifid = '{1'b1, fetchPc, fetchHit, fetchTarget, 2'd0};
      end
    end
  endtask

  task automatic step(input logic [15:0] fpc, input logic fhit, input logic [15:0] ftgt,
                      input logic [1:0] bt, input logic cond, input logic [15:0] ctgt);
    drv(1, 0, 0, 0, fpc, fhit, ftgt, bt, cond, ctgt);
    tick();
  endtask

  initial begin
    logic [15:0] rpc;
    // reset and idle
    drv(0, 0, 0, 0, 16'h0, 0, 16'h0, 2'd0, 0, 16'h0); tick();
    drv(0, 1, 0, 1, 16'h0, 0, 16'h0, 2'd0, 0, 16'h0); tick();
    drv(1, 0, 0, 0, 16'h1000, 0, 16'h0, 2'd0, 0, 16'h0);
    chk("idle_redirect", redirect, 0);
    chk("idle_exBranchType", exBranchType, 0);
    chk("idle_exPc", exPc, 0);
    chk("idle_branchCnt", branchCnt, 0);
    chk("idle_mispredCnt", mispredCnt, 0);
    tick();

    // correctly predicted taken B-type
    step(16'h0040, 1, 16'h0080, 2'd0, 0, 16'h0);
    step(16'h0044, 0, 16'h0, 2'd2, 0, 16'h0);
    drv(1, 0, 0, 0, 16'h0048, 0, 16'h0, 2'd0, 1, 16'h0080);
    chk("b_ok_redirect", redirect, 0);
    chk("b_ok_type", exBranchType, 2);
    chk("b_ok_taken", exTaken, 1);
    tick(); #1;
    chk("b_ok_branchCnt", branchCnt, 1);

    // same branch resolves not-taken: mispredict back to pc+4
    step(16'h0040, 1, 16'h0080, 2'd0, 0, 16'h0);
    step(16'h0044, 0, 16'h0, 2'd2, 0, 16'h0);
    drv(1, 0, 0, 0, 16'h0048, 0, 16'h0, 2'd0, 0, 16'h0080);
    chk("b_mp_redirect", redirect, 1);
    chk("b_mp_redirectPc", redirectPc, 16'h0044);
    chk("b_mp_flush", flush, 1);
    tick(); #1;
    chk("b_mp_mispredCnt", mispredCnt, 1);
    chk("b_mp_ifid_valid", dut.r_ifid_valid, 0);
    chk("b_mp_idex_valid", dut.r_idex_valid, 0);

    // JAL not predicted, then JALR mispredict
    step(16'h0010, 0, 16'h0, 2'd0, 0, 16'h0);
    step(16'h0014, 0, 16'h0, 2'd1, 0, 16'h0);
    drv(1, 0, 0, 0, 16'h0018, 0, 16'h0, 2'd0, 0, 16'h0100);
    chk("jal_redirect", redirect, 1);
    chk("jal_redirectPc", redirectPc, 16'h0100);
    chk("jal_type", exBranchType, 1);
    tick();
    step(16'h0020, 0, 16'h0, 2'd0, 0, 16'h0);
    step(16'h0024, 0, 16'h0, 2'd3, 0, 16'h0);
    drv(1, 0, 0, 0, 16'h0028, 0, 16'h0, 2'd0, 0, 16'h0200);
    chk("jalr_redirect", redirect, 1);
    chk("jalr_type", exBranchType, 0);
    tick();

    // mispredict held in EX under a 3-cycle data-memory stall
    step(16'h0040, 1, 16'h0080, 2'd0, 0, 16'h0);
    step(16'h0044, 0, 16'h0, 2'd2, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 1, 0, 16'h0048, 0, 16'h0, 2'd0, 0, 16'h0080);
      chk("stall_redirect", redirect, 0);
      tick();
    end
    drv(1, 0, 0, 0, 16'h0048, 0, 16'h0, 2'd0, 0, 16'h0080);
    chk("unstall_redirect", redirect, 1);
    tick();

    // one hazard cycle yields exactly one bubble ahead of the held branch
    step(16'h0060, 0, 16'h0, 2'd0, 0, 16'h0);
    drv(1, 0, 0, 1, 16'h0064, 0, 16'h0, 2'd2, 0, 16'h0); tick();
    drv(1, 0, 0, 0, 16'h0064, 0, 16'h0, 2'd2, 0, 16'h0);
    chk("bubble_type", exBranchType, 0);
    tick();
    drv(1, 0, 0, 0, 16'h0068, 0, 16'h0, 2'd0, 0, 16'h0);
    chk("after_bubble_type", exBranchType, 2);
    tick();

    // saturate the 4-bit counters; also crosses the 16-bit pc wrap
    for (int i = 0; i < 20; i++) step(16'hFFF0 + 16'(4 * (i % 4)), 0, 16'h0, 2'd2, 0, 16'h0);
    #1;
    chk("sat_branchCnt_w4", branchCnt4, 4'hF);
    step(16'h0100, 0, 16'h0, 2'd2, 0, 16'h0);
    #1;
    chk("sat_hold_w4", branchCnt4, 4'hF);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom) & 16'hFFFC;
      drv(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 7) == 0), rpc, 1'($urandom), 16'($urandom) & 16'hFFFC,
          2'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 0) ? m_idex.ptg : 16'($urandom) & 16'hFFFC);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
